// File: rtl/cc_pkg.sv
// Shared colour-combiner types: source selector encodings, Q4.12 constants,
// the per-cycle mode word layout and the per-channel (A-B)*C+D arithmetic.
package cc_pkg;

    localparam logic [15:0] Q_ZERO = 16'h0000;
    localparam logic [15:0] Q_HALF = 16'h0800;
    localparam logic [15:0] Q_ONE  = 16'h1000;

    typedef enum logic [3:0] {
        SRC_COMBINED = 4'd0,
        SRC_TEX0     = 4'd1,
        SRC_TEX1     = 4'd2,
        SRC_SHADE0   = 4'd3,
        SRC_CONST0   = 4'd4,
        SRC_CONST1   = 4'd5,
        SRC_ONE      = 4'd6,
        SRC_ZERO     = 4'd7,
        SRC_SHADE1   = 4'd8
    } cc_src_e;

    typedef enum logic [3:0] {
        CSRC_COMBINED   = 4'd0,
        CSRC_TEX0       = 4'd1,
        CSRC_TEX1       = 4'd2,
        CSRC_SHADE0     = 4'd3,
        CSRC_CONST0     = 4'd4,
        CSRC_CONST1     = 4'd5,
        CSRC_ONE        = 4'd6,
        CSRC_ZERO       = 4'd7,
        CSRC_TEX0_A     = 4'd8,
        CSRC_TEX1_A     = 4'd9,
        CSRC_SHADE0_A   = 4'd10,
        CSRC_CONST0_A   = 4'd11,
        CSRC_CONST1_A   = 4'd12,
        CSRC_COMBINED_A = 4'd13,
        CSRC_SHADE1_A   = 4'd14,
        CSRC_ZERO_HI    = 4'd15
    } cc_csrc_e;

    typedef struct packed {
        logic [3:0] alpha_d;
        logic [3:0] alpha_c;
        logic [3:0] alpha_b;
        logic [3:0] alpha_a;
        logic [3:0] rgb_d;
        logic [3:0] rgb_c;
        logic [3:0] rgb_b;
        logic [3:0] rgb_a;
    } cc_cycle_t;

    // UNORM8 -> Q4.12; 0xFF maps to exactly one.
    function automatic logic [15:0] cc_u8_to_q(input logic [7:0] x);
        return (x == 8'hFF) ? Q_ONE : {4'h0, x, 4'h0};
    endfunction

    function automatic logic [63:0] cc_const_to_q(input logic [31:0] c);
        return {cc_u8_to_q(c[31:24]), cc_u8_to_q(c[23:16]),
                cc_u8_to_q(c[15:8]),  cc_u8_to_q(c[7:0])};
    endfunction

    // (a-b)*c rounded half-up at bit 12, plus d, clamped to [0, one].
    // Arithmetic is done in two's complement on unsigned vectors.
    function automatic logic [15:0] cc_channel(input logic [15:0] a, b, c, d);
        logic [16:0] diff;
        logic [33:0] prod;
        logic [33:0] rnd;
        logic [22:0] sum;
        diff = {a[15], a} - {b[15], b};
        prod = {{17{diff[16]}}, diff} * {{18{c[15]}}, c};
        rnd  = prod + 34'h800;
        sum  = {rnd[33], rnd[33:12]} + {{7{d[15]}}, d};
        if (sum[22])
            return Q_ZERO;
        else if (sum[21:0] > {6'h0, Q_ONE})
            return Q_ONE;
        else
            return sum[15:0];
    endfunction

endpackage

// File: rtl/cc_cycle_unit.sv
// One combiner cycle: operand selection for RGB and alpha, then four
// channels of saturated (A-B)*C+D. Channel 3 is R, channel 0 is A.
module cc_cycle_unit
    import cc_pkg::*;
(
    input  logic [31:0] i_mode,
    input  logic [63:0] i_combined,
    input  logic [63:0] i_tex0,
    input  logic [63:0] i_tex1,
    input  logic [63:0] i_shade0,
    input  logic [63:0] i_shade1,
    input  logic [63:0] i_const0,
    input  logic [63:0] i_const1,
    output logic [63:0] o_result
);
    cc_cycle_t w_m;
    assign w_m = cc_cycle_t'(i_mode);

    function automatic logic [63:0] src_mux(input logic [3:0] sel,
        input logic [63:0] cmb, t0, t1, s0, s1, k0, k1);
        case (sel)
            SRC_COMBINED: return cmb;
            SRC_TEX0:     return t0;
            SRC_TEX1:     return t1;
            SRC_SHADE0:   return s0;
            SRC_CONST0:   return k0;
            SRC_CONST1:   return k1;
            SRC_ONE:      return {4{Q_ONE}};
            SRC_SHADE1:   return s1;
            default:      return {4{Q_ZERO}};
        endcase
    endfunction

    // rgb_c can also broadcast a source's alpha across R, G and B.
    function automatic logic [63:0] csrc_mux(input logic [3:0] sel,
        input logic [63:0] cmb, t0, t1, s0, s1, k0, k1);
        case (sel)
            CSRC_TEX0_A:     return {4{t0[15:0]}};
            CSRC_TEX1_A:     return {4{t1[15:0]}};
            CSRC_SHADE0_A:   return {4{s0[15:0]}};
            CSRC_CONST0_A:   return {4{k0[15:0]}};
            CSRC_CONST1_A:   return {4{k1[15:0]}};
            CSRC_COMBINED_A: return {4{cmb[15:0]}};
            CSRC_SHADE1_A:   return {4{s1[15:0]}};
            CSRC_ZERO_HI:    return {4{Q_ZERO}};
            default:         return src_mux(sel, cmb, t0, t1, s0, s1, k0, k1);
        endcase
    endfunction

    logic [63:0] w_rgb_a, w_rgb_b, w_rgb_c, w_rgb_d;
    logic [63:0] w_al_a, w_al_b, w_al_c, w_al_d;
    logic [63:0] w_op_a, w_op_b, w_op_c, w_op_d;

    assign w_rgb_a = src_mux (w_m.rgb_a,   i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_rgb_b = src_mux (w_m.rgb_b,   i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_rgb_c = csrc_mux(w_m.rgb_c,   i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_rgb_d = src_mux (w_m.rgb_d,   i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_al_a  = src_mux (w_m.alpha_a, i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_al_b  = src_mux (w_m.alpha_b, i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_al_c  = src_mux (w_m.alpha_c, i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);
    assign w_al_d  = src_mux (w_m.alpha_d, i_combined, i_tex0, i_tex1, i_shade0, i_shade1, i_const0, i_const1);

    // Alpha channel takes the A lane of the alpha selections; RGB lanes the rest.
    assign w_op_a = {w_rgb_a[63:16], w_al_a[15:0]};
    assign w_op_b = {w_rgb_b[63:16], w_al_b[15:0]};
    assign w_op_c = {w_rgb_c[63:16], w_al_c[15:0]};
    assign w_op_d = {w_rgb_d[63:16], w_al_d[15:0]};

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        assign o_result[ch*16 +: 16] = cc_channel(w_op_a[ch*16 +: 16], w_op_b[ch*16 +: 16],
                                                  w_op_c[ch*16 +: 16], w_op_d[ch*16 +: 16]);
    end

endmodule

// File: rtl/color_combiner.sv
// Two-stage colour combiner with ready/valid handshake. Define
// COLOR_COMBINER_TWO_CYCLE_EN to evaluate the second combiner cycle.
module color_combiner
    import cc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] tex_color0,
    input  logic [63:0] tex_color1,
    input  logic [63:0] shade0,
    input  logic [63:0] shade1,
    input  logic [15:0] frag_x,
    input  logic [15:0] frag_y,
    input  logic [15:0] frag_z,
    input  logic        frag_valid,
    output logic        in_ready,
    input  logic [63:0] cc_mode,
    input  logic [63:0] const_color,
    output logic [63:0] combined_color,
    output logic [15:0] out_frag_x,
    output logic [15:0] out_frag_y,
    output logic [15:0] out_frag_z,
    output logic        out_frag_valid,
    input  logic        out_ready
);
    logic [1:0]  r_vld;
    logic        w_s1_adv, w_accept;
    logic [63:0] w_const0, w_const1, w_c0_res, w_s1_next;
    logic [63:0] r_s0_color;
    logic [15:0] r_s0_x, r_s0_y, r_s0_z;

    assign w_s1_adv = out_ready || !r_vld[1];
    assign in_ready = !r_vld[0] || w_s1_adv;
    assign w_accept = frag_valid && in_ready;
    assign w_const0 = cc_const_to_q(const_color[31:0]);
    assign w_const1 = cc_const_to_q(const_color[63:32]);

    cc_cycle_unit u_cycle0 (
        .i_mode     (cc_mode[31:0]),
        .i_combined ({4{Q_ZERO}}),
        .i_tex0     (tex_color0),
        .i_tex1     (tex_color1),
        .i_shade0   (shade0),
        .i_shade1   (shade1),
        .i_const0   (w_const0),
        .i_const1   (w_const1),
        .o_result   (w_c0_res)
    );

`ifdef COLOR_COMBINER_TWO_CYCLE_EN
    // Cycle 1 runs a clock later, so its texture/shade operands travel along.
    logic [63:0] r_s0_tex0, r_s0_tex1, r_s0_shade0, r_s0_shade1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_tex0   <= '0;
            r_s0_tex1   <= '0;
            r_s0_shade0 <= '0;
            r_s0_shade1 <= '0;
        end else if (w_accept) begin
            r_s0_tex0   <= tex_color0;
            r_s0_tex1   <= tex_color1;
            r_s0_shade0 <= shade0;
            r_s0_shade1 <= shade1;
        end
    end

    cc_cycle_unit u_cycle1 (
        .i_mode     (cc_mode[63:32]),
        .i_combined (r_s0_color),
        .i_tex0     (r_s0_tex0),
        .i_tex1     (r_s0_tex1),
        .i_shade0   (r_s0_shade0),
        .i_shade1   (r_s0_shade1),
        .i_const0   (w_const0),
        .i_const1   (w_const1),
        .o_result   (w_s1_next)
    );
`else
    logic w_unused_c1;
    assign w_unused_c1 = ^cc_mode[63:32];
    assign w_s1_next   = r_s0_color;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld          <= '0;
            r_s0_color     <= '0;
            r_s0_x         <= '0;
            r_s0_y         <= '0;
            r_s0_z         <= '0;
            combined_color <= '0;
            out_frag_x     <= '0;
            out_frag_y     <= '0;
            out_frag_z     <= '0;
        end else begin
            if (in_ready) begin
                r_vld[0] <= w_accept;
                if (w_accept) begin
                    r_s0_color <= w_c0_res;
                    r_s0_x     <= frag_x;
                    r_s0_y     <= frag_y;
                    r_s0_z     <= frag_z;
                end
            end
            // Bubbles only clear valid; data holds its last value.
            if (w_s1_adv) begin
                r_vld[1] <= r_vld[0];
                if (r_vld[0]) begin
                    combined_color <= w_s1_next;
                    out_frag_x     <= r_s0_x;
                    out_frag_y     <= r_s0_y;
                    out_frag_z     <= r_s0_z;
                end
            end
        end
    end

    assign out_frag_valid = r_vld[1];

endmodule

// File: tb/tb_color_combiner.sv
// Directed bench for color_combiner; expectations follow the build's
// COLOR_COMBINER_TWO_CYCLE_EN setting where the two builds differ.
module tb_color_combiner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tex_color0, tex_color1, shade0, shade1, cc_mode, const_color;
    logic [15:0] frag_x, frag_y, frag_z;
    logic        frag_valid, in_ready, out_ready, out_frag_valid;
    logic [63:0] combined_color;
    logic [15:0] out_frag_x, out_frag_y, out_frag_z;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] PASS = 32'h76707670;  // COMBINED*ONE on all channels

    color_combiner dut (
        .clk(clk), .rst_n(rst_n),
        .tex_color0(tex_color0), .tex_color1(tex_color1),
        .shade0(shade0), .shade1(shade1),
        .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z),
        .frag_valid(frag_valid), .in_ready(in_ready),
        .cc_mode(cc_mode), .const_color(const_color),
        .combined_color(combined_color),
        .out_frag_x(out_frag_x), .out_frag_y(out_frag_y), .out_frag_z(out_frag_z),
        .out_frag_valid(out_frag_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] t0, t1, s0, s1, mode, cc, input logic [15:0] x);
        tex_color0 = t0; tex_color1 = t1; shade0 = s0; shade1 = s1;
        cc_mode = mode; const_color = cc;
        frag_x = x; frag_y = x + 16'd1; frag_z = ~x;
    endtask

    // Single fragment with out_ready high: result appears exactly 2 clocks later.
    task automatic run_one(input string tag, input logic [63:0] t0, t1, s0, s1, mode, cc,
                           input logic [15:0] x, input logic [63:0] exp);
        @(negedge clk);
        drive(t0, t1, s0, s1, mode, cc, x);
        frag_valid = 1'b1;
        chk({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
        @(posedge clk); @(negedge clk);
        frag_valid = 1'b0;
        chk({tag, "_lat1_valid"}, {63'h0, out_frag_valid}, 64'h0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid"}, {63'h0, out_frag_valid}, 64'h1);
        chk({tag, "_color"}, combined_color, exp);
        chk({tag, "_xyz"}, {16'h0, out_frag_x, out_frag_y, out_frag_z},
            {16'h0, x, x + 16'd1, ~x});
    endtask

    initial begin
        logic [63:0] fog_exp;
`ifdef COLOR_COMBINER_TWO_CYCLE_EN
        fog_exp = 64'h0800_0800_0800_0000;
`else
        fog_exp = 64'h0;
`endif
        rst_n = 1'b0; frag_valid = 1'b0; out_ready = 1'b1;
        drive('0, '0, '0, '0, '0, '0, 16'h0);
        #1;
        chk("rst_valid", {63'h0, out_frag_valid}, 64'h0);
        chk("rst_color", combined_color, 64'h0);
        chk("rst_xyz", {16'h0, out_frag_x, out_frag_y, out_frag_z}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {63'h0, in_ready}, 64'h1);

        run_one("modulate", {4{16'h0800}}, '0, {4{16'h0800}}, '0,
                {PASS, 32'h73717371}, '0, 16'h0011, {4{16'h0400}});
        @(negedge clk);
        chk("bubble_valid", {63'h0, out_frag_valid}, 64'h0);
        chk("bubble_hold", combined_color, {4{16'h0400}});

        run_one("saturate", '0, '0, '0, '0, {2{32'h66766676}}, '0, 16'h0022, {4{16'h1000}});
        run_one("combined", '0, '0, 64'h0C00_0800_0400_1000, '0,
                {PASS, 32'h76737673}, '0, 16'h0033, 64'h0C00_0800_0400_1000);
        run_one("fog", '0, '0, '0, 64'h0100_0100_0100_0800,
                {32'h07770E05, PASS}, {32'hFFFFFFFF, 32'h0}, 16'h0044, fog_exp);
        run_one("neg_clamp", '0, '0, '0, '0, {2{32'h76677667}}, '0, 16'h0055, 64'h0);
        run_one("const_conv", '0, '0, '0, '0, {PASS, 32'h76757674},
                {32'h000000FF, 32'h80FF1001}, 16'h0066, 64'h0800_1000_0100_1000);
        run_one("round", 64'h0001_0001_0003_0002, '0, 64'h0800_07FF_0800_0800, '0,
                {PASS, 32'h73717371}, '0, 16'h0077, 64'h0001_0000_0002_0001);
        run_one("alpha_bcast", 64'h0100_0100_0100_0800, 64'h1000_0800_0400_0000,
                64'h0000_0000_0000_0200, 64'h0010_0020_0030_0040,
                {PASS, 32'h76318872}, '0, 16'h0088, 64'h0810_0420_0230_0600);

        // Backpressure: two fragments fill the pipe, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        drive({4{16'h0800}}, '0, {4{16'h0800}}, '0, {PASS, 32'h73717371}, '0, 16'h0101);
        frag_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_ready_after1", {63'h0, in_ready}, 64'h1);
        drive({4{16'h0800}}, '0, {4{16'h0800}}, '0, {PASS, 32'h73717371}, '0, 16'h0102);
        @(posedge clk); @(negedge clk);
        chk("bp_ready_after2", {63'h0, in_ready}, 64'h0);
        drive({4{16'h0800}}, '0, {4{16'h0800}}, '0, {PASS, 32'h73717371}, '0, 16'h0103);
        repeat (3) @(negedge clk);
        chk("bp_stall_ready", {63'h0, in_ready}, 64'h0);
        chk("bp_stall_out", {47'h0, out_frag_valid, out_frag_x}, {47'h0, 1'b1, 16'h0101});
        chk("bp_stall_color", combined_color, {4{16'h0400}});
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk); @(negedge clk);
        frag_valid = 1'b0;
        chk("bp_out2", {47'h0, out_frag_valid, out_frag_x}, {47'h0, 1'b1, 16'h0102});
        @(posedge clk); @(negedge clk);
        chk("bp_out3", {47'h0, out_frag_valid, out_frag_x}, {47'h0, 1'b1, 16'h0103});
        chk("bp_out3_z", {48'h0, out_frag_z}, {48'h0, ~16'h0103});
        @(posedge clk); @(negedge clk);
        chk("bp_drained", {63'h0, out_frag_valid}, 64'h0);

        // Reset while a fragment is held at the output.
        out_ready = 1'b0;
        drive({4{16'h0800}}, '0, {4{16'h0800}}, '0, {PASS, 32'h73717371}, '0, 16'h0055);
        frag_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        frag_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_held", {63'h0, out_frag_valid}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, out_frag_valid}, 64'h0);
        chk("mid_rst_color", combined_color, 64'h0);
        chk("mid_rst_x", {48'h0, out_frag_x}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_empty", {63'h0, out_frag_valid}, 64'h0);
        run_one("post_rst", {4{16'h0800}}, '0, {4{16'h0800}}, '0,
                {PASS, 32'h73717371}, '0, 16'h0099, {4{16'h0400}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/color_combiner.md
COLOR_COMBINER -- requirements
Module: color_combiner

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The module SHALL provide these inputs: tex_color0, tex_color1, shade0, shade1  in  64 each  Q4.12 signed RGBA, packed R[63:48], G[47:32], B[31:16], A[15:0].
REQ-003 The module SHALL provide frag_x, frag_y, frag_z  in  16 each  fragment position and depth, passed through unmodified.
REQ-004 The module SHALL provide frag_valid  in  1  input fragment valid, and in_ready  out  1  the module can accept a fragment.
REQ-005 The module SHALL provide cc_mode  in  64  combiner mode: cycle 0 in [31:0], cycle 1 in [63:32].
REQ-006 Each cc_mode cycle word SHALL be packed as rgb_a[3:0], rgb_b[7:4], rgb_c[11:8], rgb_d[15:12], alpha_a[19:16], alpha_b[23:20], alpha_c[27:24], alpha_d[31:28].
REQ-007 The module SHALL provide const_color  in  64  CONST0 in [31:0] and CONST1 in [63:32], each RGBA8888 with R in the top byte.
REQ-008 The module SHALL provide combined_color  out  64  Q4.12 RGBA result, packed as in REQ-002.
REQ-009 The module SHALL provide out_frag_x, out_frag_y, out_frag_z  out  16 each, and out_frag_valid  out  1.
REQ-010 The module SHALL provide out_ready  in  1  downstream accepts the output fragment.

Function
REQ-011 The source encoding for rgb_a, rgb_b, rgb_d and all four alpha selectors SHALL be: 0 COMBINED, 1 TEX0, 2 TEX1, 3 SHADE0, 4 CONST0, 5 CONST1, 6 ONE (0x1000), 7 ZERO, 8 SHADE1, 9-15 ZERO.
REQ-012 The rgb_c encoding SHALL be: 0-7 as REQ-011, 8 TEX0_ALPHA, 9 TEX1_ALPHA, 10 SHADE0_ALPHA, 11 CONST0_ALPHA, 12 CONST1_ALPHA, 13 COMBINED_ALPHA, 14 SHADE1_ALPHA, 15 ZERO; an *_ALPHA source SHALL broadcast that source's A channel to R, G and B.
REQ-013 Alpha selectors SHALL use the A channel of the selected source.
REQ-014 CONST0 and CONST1 UNORM8 channels SHALL convert to Q4.12 as 0xFF -> 0x1000, otherwise x << 4.
REQ-015 Each channel of each cycle SHALL compute (A - B) * C + D: A - B in 17-bit signed, product in 34-bit signed, shifted right 12 bits with round-half-up (add 0x800 before the shift), then D added.
REQ-016 Each cycle result SHALL saturate per channel to [0x0000, 0x1000].
REQ-017 In cycle 0, the COMBINED source SHALL read as zero.
REQ-018 In cycle 1, the COMBINED source SHALL be the saturated cycle-0 result of the same fragment.
REQ-019 The pipeline SHALL have two register stages: stage 0 registers the cycle-0 result, stage 1 registers the cycle-1 result; latency is 2 clocks from acceptance to out_frag_valid.
REQ-020 Stage 1 SHALL advance when out_ready or !out_frag_valid; stage 0 SHALL advance when stage 1 advances or stage 0 is empty; in_ready SHALL equal !stage0_valid || stage1_advance.
REQ-021 A fragment SHALL be accepted when frag_valid && in_ready.
REQ-022 Data registers SHALL load only when a valid fragment advances into them; bubbles SHALL clear the valid bits but leave data unchanged.
REQ-023 Position and depth SHALL travel with their colour through both stages.
REQ-024 cc_mode and const_color SHALL be sampled at the stage that uses them and are quasi-static.

Reset
REQ-025 On reset, all valid bits, combined_color and out_frag_x/y/z SHALL be 0, and in_ready SHALL be 1 once reset is released.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight fragments.

Configuration
REQ-027 With COLOR_COMBINER_TWO_CYCLE_EN defined, cycle 1 SHALL be evaluated per REQ-018.
REQ-028 Without COLOR_COMBINER_TWO_CYCLE_EN, the cycle-1 fields SHALL be ignored, stage 1 SHALL register the cycle-0 result unchanged, and the latency SHALL remain 2.

Structure
REQ-029 A shared package cc_pkg SHALL hold the source enums (REQ-011, REQ-012), the Q4.12 ZERO/HALF/ONE constants, and the cycle-field type.
REQ-030 A sub-module cc_cycle_unit SHALL implement one cycle: operand muxing plus four channels of (A-B)*C+D with saturation; it SHALL be instantiated twice.

Verification
REQ-031 Modulate test: TEX0 = SHADE0 = 0x0800 on all channels, cycle 0 = (TEX0-ZERO)*SHADE0+ZERO, cycle 1 = COMBINED*ONE -> all channels 0x0400 (±1) two clocks after acceptance.
REQ-032 Saturation test: both cycles ONE*ONE+ONE -> all channels 0x1000.
REQ-033 COMBINED test: SHADE0 = {0x0C00, 0x0800, 0x0400, 0x1000}, cycle 0 passes SHADE0, cycle 1 passes COMBINED -> output exactly equals SHADE0.
REQ-034 Fog test: cycle 1 = (CONST1-COMBINED)*SHADE1_ALPHA+COMBINED with SHADE1 A = 0x0800, CONST1 = white, COMBINED = 0 -> RGB 0x0800.
REQ-035 Backpressure test: out_ready = 0 with 3 fragments sent -> in_ready falls after 2 fragments are held, no loss or reordering, out_frag_x values preserved in order.
REQ-036 Negative clamp test: (ZERO-ONE)*ONE+ZERO -> 0x0000; reset asserted mid-stream -> out_frag_valid = 0 immediately.
